// File: rtl/delay_var_sv.sv
// Variable-depth delay line: data and its valid qualifier are delayed by a runtime-selectable
// number of ena-qualified cycles, with q_valid suppressed while the pipeline refills.
module delay_var_sv #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned MAX_CYCLES  = 16,
  parameter int unsigned DEFAULT_DLY = 1,
  localparam int unsigned DLY_W      = $clog2(MAX_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
  input  logic [DLY_W-1:0] dly,
  input  logic             dly_ld,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  output logic             settling,
  output logic             dly_err
);

  logic [WIDTH-1:0]      stage_q [MAX_CYCLES];
  logic [MAX_CYCLES-1:0] valid_q;
  logic [DLY_W-1:0]      dly_q;
  logic [DLY_W-1:0]      dly_eff;
  logic [DLY_W-1:0]      settle_q, settle_d;
  logic                  dly_err_q;
  logic                  dly_over;

  assign dly_over = dly > DLY_W'(MAX_CYCLES);
  assign dly_eff  = dly_over ? DLY_W'(MAX_CYCLES) : dly;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < MAX_CYCLES; i++) begin
        stage_q[i] <= '0;
      end
      valid_q <= '0;
    end else if (clr) begin
      for (int unsigned i = 0; i < MAX_CYCLES; i++) begin
        stage_q[i] <= '0;
      end
      valid_q <= '0;
    end else if (ena) begin
      stage_q[0] <= d;
      valid_q[0] <= d_valid;
      for (int unsigned i = 1; i < MAX_CYCLES; i++) begin
        stage_q[i] <= stage_q[i-1];
        valid_q[i] <= valid_q[i-1];
      end
    end
  end

  // The delay select loads regardless of ena and clr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dly_q <= DLY_W'(DEFAULT_DLY);
    end else if (dly_ld) begin
      dly_q <= dly_eff;
    end
  end

  // A load always restarts the count from the full new delay; clr on the same edge forces zero.
  always_comb begin
    settle_d = settle_q;
    if (dly_ld) begin
      settle_d = clr ? '0 : dly_eff;
    end else if (clr) begin
      settle_d = '0;
    end else if (ena && (settle_q != '0)) begin
      settle_d = settle_q - DLY_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      settle_q  <= '0;
      dly_err_q <= 1'b0;
    end else begin
      settle_q <= settle_d;
      if (dly_ld && dly_over) begin
        dly_err_q <= 1'b1;
      end else if (clr) begin
        dly_err_q <= 1'b0;
      end
    end
  end

  assign settling = settle_q != '0;
  assign dly_err  = dly_err_q;

  always_comb begin
    q       = d;
    q_valid = d_valid;
    if (dly_q != '0) begin
      q       = '0;
      q_valid = 1'b0;
      for (int unsigned i = 0; i < MAX_CYCLES; i++) begin
        if (dly_q == DLY_W'(i + 1)) begin
          q       = stage_q[i];
          q_valid = valid_q[i] & ~settling;
        end
      end
    end
  end

endmodule

// File: tb/tb_delay_var_sv.sv
// Bench for delay_var_sv: directed vector table, hand-written corner sequences, then random
// traffic compared against a queue-based reference model.
module tb_delay_var_sv;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned MAXC  = 16;
  localparam int unsigned DLYW  = 5;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            ena = 1'b0;
  logic            clr = 1'b0;
  logic [WIDTH-1:0] d = '0;
  logic            d_valid = 1'b0;
  logic [DLYW-1:0] dly = '0;
  logic            dly_ld = 1'b0;
  logic [WIDTH-1:0] q;
  logic            q_valid;
  logic            settling;
  logic            dly_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  delay_var_sv #(
    .WIDTH      (WIDTH),
    .MAX_CYCLES (MAXC),
    .DEFAULT_DLY(1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .clr     (clr),
    .d       (d),
    .d_valid (d_valid),
    .dly     (dly),
    .dly_ld  (dly_ld),
    .q       (q),
    .q_valid (q_valid),
    .settling(settling),
    .dly_err (dly_err)
  );

  // Reference model: history of ena-qualified samples, newest first.
  typedef struct packed {
    logic [WIDTH-1:0] d;
    logic             v;
  } smp_t;

  smp_t hist[$];
  int   m_dly;
  int   m_load;
  int   m_since;
  bit   m_err;

  task automatic mdl_reset();
    hist.delete();
    for (int i = 0; i < MAXC; i++) hist.push_back('0);
    m_dly   = 1;
    m_load  = 0;
    m_since = 0;
    m_err   = 0;
  endtask

  // Called at the rising edge with the inputs the DUT samples on that edge.
  task automatic mdl_edge();
    int req;
    int eff;
    req = int'(dly);
    eff = (req > MAXC) ? MAXC : req;
    if (clr) begin
      for (int i = 0; i < MAXC; i++) hist[i] = '0;
    end else if (ena) begin
      hist.push_front({d, d_valid});
      void'(hist.pop_back());
    end
    if (dly_ld) begin
      m_dly   = eff;
      m_since = 0;
      m_load  = clr ? 0 : eff;
    end else if (clr) begin
      m_load = 0;
    end else if (ena && m_since < 1000) begin
      m_since++;
    end
    if (dly_ld && req > MAXC) m_err = 1;
    else if (clr) m_err = 0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_model();
    bit       m_set;
    logic [WIDTH-1:0] eq;
    bit       eqv;
    m_set = m_since < m_load;
    if (m_dly == 0) begin
      eq  = d;
      eqv = d_valid;
    end else begin
      eq  = hist[m_dly-1].d;
      eqv = hist[m_dly-1].v && !m_set;
    end
    chk("mdl_q", 32'(q), 32'(eq));
    chk("mdl_q_valid", 32'(q_valid), 32'(eqv));
    chk("mdl_settling", 32'(settling), 32'(m_set));
    chk("mdl_dly_err", 32'(dly_err), 32'(m_err));
  endtask

  // Apply inputs, take one edge, update the model, and leave time for outputs to settle.
  task automatic cycle(input logic e, input logic c, input logic [WIDTH-1:0] dd, input logic v,
                       input logic [DLYW-1:0] dl, input logic ld);
    ena = e; clr = c; d = dd; d_valid = v; dly = dl; dly_ld = ld;
    @(posedge clk);
    mdl_edge();
    #1;
  endtask

  typedef struct {
    logic             ena;
    logic             clr;
    logic [WIDTH-1:0] d;
    logic             dv;
    logic [DLYW-1:0]  dly;
    logic             ld;
    logic [WIDTH-1:0] eq;
    logic             eqv;
    logic             eset;
    logic             eerr;
  } vec_t;

  vec_t tbl[13];

  initial begin
    // ena clr d dv dly ld | q qv settling err   (checked after the edge, inputs held)
    tbl[0]  = '{1'b1, 1'b0, 8'h11, 1'b1, 5'd0,  1'b0, 8'h11, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 8'h22, 1'b1, 5'd0,  1'b0, 8'h11, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 8'h22, 1'b0, 5'd0,  1'b0, 8'h22, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 8'h33, 1'b1, 5'd2,  1'b1, 8'h22, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 8'h44, 1'b1, 5'd0,  1'b0, 8'h33, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 8'h55, 1'b1, 5'd0,  1'b0, 8'h33, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 8'h55, 1'b1, 5'd0,  1'b0, 8'h44, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 8'h66, 1'b1, 5'd20, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1};
    tbl[8]  = '{1'b0, 1'b1, 8'h77, 1'b1, 5'd0,  1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 8'h88, 1'b1, 5'd0,  1'b1, 8'h88, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 8'h99, 1'b0, 5'd0,  1'b0, 8'h99, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 8'h12, 1'b1, 5'd31, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1};
    tbl[12] = '{1'b1, 1'b0, 8'h5a, 1'b1, 5'd3,  1'b1, 8'h00, 1'b0, 1'b1, 1'b1};

    mdl_reset();
    rst = 1'b1;
    d = 8'haa; d_valid = 1'b1;
    #12;
    chk("rst_q", 32'(q), 32'h0);
    chk("rst_q_valid", 32'(q_valid), 32'h0);
    chk("rst_settling", 32'(settling), 32'h0);
    chk("rst_dly_err", 32'(dly_err), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;

    for (int i = 0; i < 13; i++) begin
      cycle(tbl[i].ena, tbl[i].clr, tbl[i].d, tbl[i].dv, tbl[i].dly, tbl[i].ld);
      chk($sformatf("vec%0d_q", i), 32'(q), 32'(tbl[i].eq));
      chk($sformatf("vec%0d_q_valid", i), 32'(q_valid), 32'(tbl[i].eqv));
      chk($sformatf("vec%0d_settling", i), 32'(settling), 32'(tbl[i].eset));
      chk($sformatf("vec%0d_dly_err", i), 32'(dly_err), 32'(tbl[i].eerr));
    end

    // Delay 5 from an empty pipeline: first valid appears on the 5th edge after 0x01.
    cycle(1'b0, 1'b1, 8'h00, 1'b0, 5'd5, 1'b1);
    chk("d5_settling", 32'(settling), 32'h0);
    for (int k = 1; k <= 16; k++) begin
      cycle(1'b1, 1'b0, 8'(k), 1'b1, 5'd0, 1'b0);
      chk($sformatf("d5_qv_%0d", k), 32'(q_valid), 32'(k >= 5));
      if (k >= 5) chk($sformatf("d5_q_%0d", k), 32'(q), 32'(k - 4));
    end

    // Asynchronous reset with valids in flight: nothing valid until new data passes through.
    rst = 1'b1;
    #1;
    mdl_reset();
    chk("midrst_q", 32'(q), 32'h0);
    chk("midrst_q_valid", 32'(q_valid), 32'h0);
    rst = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 1'b0, 8'(k + 1), 1'b0, 5'd0, 1'b0);
      chk($sformatf("postrst_qv_%0d", k), 32'(q_valid), 32'h0);
    end
    cycle(1'b1, 1'b0, 8'ha5, 1'b1, 5'd0, 1'b0);
    chk("postrst_q", 32'(q), 32'ha5);
    chk("postrst_q_valid", 32'(q_valid), 32'h1);

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        rst = 1'b1;
        #1;
        mdl_reset();
        rst = 1'b0;
        #1;
      end
      cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 29) == 0), 8'($urandom),
            1'($urandom), 5'($urandom_range(0, 20)), ($urandom_range(0, 11) == 0));
      chk_model();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
